proc_imm_gen_queue: RTL and testbench
=====================================

Name: proc_imm_gen_queue

Overview:
Pipelined, latency-insensitive immediate generator for the processor decode stage. Accepts {imm_type, inst, tag} on a val/rdy input stream and computes the sign/zero-extended immediate at enqueue. Results are stored in a parametrised in-order FIFO and returned on a val/rdy output stream. Decode can issue back-to-back while execute stalls. Adds S-type, corrected J-type, illegal-type flagging and tag passthrough.

Parameters:
p_depth, 2, FIFO entries (>=1); pointer width is $clog2(p_depth), minimum 1
p_tag_nbits, 4, width of opaque tag carried alongside each immediate

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_val  in  1  input request valid
in_rdy  out  1  input request ready
in_imm_type  in  3  immediate format select
in_inst  in  32  raw instruction word
in_tag  in  p_tag_nbits  opaque tag, returned unchanged
out_val  out  1  result valid
out_rdy  in  1  consumer ready
out_imm  out  32  generated immediate
out_err  out  1  1 = unsupported imm_type
out_tag  out  p_tag_nbits  tag of this result
stat_imm_count  out  32  handshaked results (optional feature)
stat_err_count  out  32  handshaked results with out_err=1 (optional feature)

Behaviour:
- Clock is clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Immediate encodings, computed combinationally from in_inst and stored at enqueue:
  - 0 I: sext(inst[31:20])
  - 1 S: sext({inst[31:25], inst[11:7]})
  - 2 B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - 3 U: {inst[31:12], 12'b0}
  - 4 J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - 5 shamt: zext(inst[24:20])
  - 6, 7: imm=0, err=1
- Enqueue fires when in_val && in_rdy. Dequeue fires when out_val && out_rdy.
- State:
  - head pointer, tail pointer and count (0..p_depth), all wrapping at p_depth. Wrap must be correct for non-power-of-two depths.
  - Storage holds {imm, err, tag} per entry.
- out_val = (count != 0).
- out_imm, out_err and out_tag come from the head entry. They are forced to 0 when count == 0.
- in_rdy = (count < p_depth) || (out_val && out_rdy). A full queue accepts a new entry in the same cycle it dequeues; this is a combinational out_rdy->in_rdy path, by design.
- Latency: an entry enqueued at edge N is first visible on out at cycle N+1. There is no empty-bypass.
- Throughput: 1 result/cycle sustained for any p_depth >= 1.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
- Empty: out_rdy is ignored and there is no pointer movement.
- Full without dequeue: in_rdy=0 and in_val is ignored.
- Results are returned strictly in FIFO order; tags never reorder.
- Reset values: count=0, head=0, tail=0, out_val=0, out_imm=0, out_err=0, out_tag=0, in_rdy=1, stats=0.
- Reset mid-operation: all entries are discarded. Storage contents are not cleared, but they are invisible while count=0.
- in_* values are don't-care when in_val=0. No X may propagate to out_* while out_val=0.

Optional Feature:
PROC_IMM_GEN_STATS_EN:
- Defined:
  - stat_imm_count increments on every dequeue handshake.
  - stat_err_count increments on each dequeue handshake with out_err=1.
  - Both are 32-bit, saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Test Plan:
1. Reset, then idle -> out_val=0, in_rdy=1, out_imm=0, stat_* = 0.
2. Single-entry encodings, out_rdy=1; each result appears on out one cycle after enqueue:
   - type 0, inst 0xFFF00093, tag 3 -> out_imm=0xFFFFFFFF, out_err=0, out_tag=3.
   - type 1, inst 0xFE112E23 -> 0xFFFFFFFC.
   - type 4, inst 0x001000EF -> 0x00000800.
3. type 5, inst 0x41F0D093 -> 0x0000001F. type 3, inst 0x12345037 -> 0x12345000.
4. p_depth=2, out_rdy=0, three back-to-back requests with tags 1,2,3 -> in_rdy drops after two enqueues and tag 3 is held off. Raising out_rdy dequeues tag 1 and enqueues tag 3 in the same cycle. Out order is 1,2,3 with 1 result/cycle.
5. type 6, any inst -> out_imm=0, out_err=1. With PROC_IMM_GEN_STATS_EN: stat_err_count=1, stat_imm_count = total handshakes.
6. Two entries queued, reset asserted for one cycle -> next cycle out_val=0, in_rdy=1. The next enqueue returns only the new entry.

Source files
------------

// File: rtl/proc_imm_gen_queue.sv
// Immediate generator for decode: computes the immediate at enqueue and queues {imm, err, tag} in order.
// Optional saturating result counters are enabled with `define PROC_IMM_GEN_STATS_EN.
module proc_imm_gen_queue #(
    parameter int p_depth     = 2,
    parameter int p_tag_nbits = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [2:0]             in_imm_type,
    input  logic [31:0]            in_inst,
    input  logic [p_tag_nbits-1:0] in_tag,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [31:0]            out_imm,
    output logic                   out_err,
    output logic [p_tag_nbits-1:0] out_tag,
    output logic [31:0]            stat_imm_count,
    output logic [31:0]            stat_err_count
);

    localparam int c_ptr_nbits = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int c_cnt_nbits = $clog2(p_depth + 1);
    localparam logic [c_ptr_nbits-1:0] c_last_ptr = c_ptr_nbits'(p_depth - 1);
    localparam logic [c_cnt_nbits-1:0] c_full_cnt = c_cnt_nbits'(p_depth);

    localparam logic [2:0] c_type_i     = 3'd0;
    localparam logic [2:0] c_type_s     = 3'd1;
    localparam logic [2:0] c_type_b     = 3'd2;
    localparam logic [2:0] c_type_u     = 3'd3;
    localparam logic [2:0] c_type_j     = 3'd4;
    localparam logic [2:0] c_type_shamt = 3'd5;

    logic [31:0]            w_imm;
    logic                   w_err;
    logic                   w_enq;
    logic                   w_deq;
    logic                   w_unused_opcode;

    logic [31:0]            r_imm_mem [p_depth];
    logic                   r_err_mem [p_depth];
    logic [p_tag_nbits-1:0] r_tag_mem [p_depth];
    logic [c_ptr_nbits-1:0] r_head;
    logic [c_ptr_nbits-1:0] r_tail;
    logic [c_cnt_nbits-1:0] r_count;

    // The opcode field never contributes to any immediate format.
    assign w_unused_opcode = &{1'b0, in_inst[6:0]};

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        w_imm = '0;
        w_err = 1'b0;
        case (in_imm_type)
            c_type_i:     w_imm = {{20{in_inst[31]}}, in_inst[31:20]};
            c_type_s:     w_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            c_type_b:     w_imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                   in_inst[30:25], in_inst[11:8], 1'b0};
            c_type_u:     w_imm = {in_inst[31:12], 12'b0};
            c_type_j:     w_imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                   in_inst[20], in_inst[30:21], 1'b0};
            c_type_shamt: w_imm = {27'b0, in_inst[24:20]};
            default:      w_err = 1'b1;
        endcase
    end

    assign out_val = (r_count != '0);
    assign w_deq   = out_val && out_rdy;
    // A full queue still accepts when the head leaves this cycle (combinational out_rdy -> in_rdy).
    assign in_rdy  = (r_count != c_full_cnt) || w_deq;
    assign w_enq   = in_val && in_rdy;

    assign out_imm = out_val ? r_imm_mem[r_head] : '0;
    assign out_err = out_val ? r_err_mem[r_head] : 1'b0;
    assign out_tag = out_val ? r_tag_mem[r_head] : '0;

    // NOTE: storage is deliberately not reset; entries are only observable while count is nonzero.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_imm_mem[r_tail] <= w_imm;
            r_err_mem[r_tail] <= w_err;
            r_tag_mem[r_tail] <= in_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= (r_tail == c_last_ptr) ? '0 : r_tail + c_ptr_nbits'(1);
            end
            if (w_deq) begin
                r_head <= (r_head == c_last_ptr) ? '0 : r_head + c_ptr_nbits'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_cnt_nbits'(1);
                2'b01:   r_count <= r_count - c_cnt_nbits'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PROC_IMM_GEN_STATS_EN
    logic [31:0] r_stat_imm;
    logic [31:0] r_stat_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_imm <= '0;
            r_stat_err <= '0;
        end else if (w_deq) begin
            if (r_stat_imm != '1) r_stat_imm <= r_stat_imm + 32'd1;
            if (out_err && (r_stat_err != '1)) r_stat_err <= r_stat_err + 32'd1;
        end
    end

    assign stat_imm_count = r_stat_imm;
    assign stat_err_count = r_stat_err;
`else
    assign stat_imm_count = '0;
    assign stat_err_count = '0;
`endif

endmodule

// File: tb/tb_proc_imm_gen_queue.sv
// Directed self-checking bench for proc_imm_gen_queue (p_depth=2, p_tag_nbits=4).
// Stat expectations follow PROC_IMM_GEN_STATS_EN when the bench is built with it.
module tb_proc_imm_gen_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [2:0]  in_imm_type;
    logic [31:0] in_inst;
    logic [3:0]  in_tag;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_imm;
    logic        out_err;
    logic [3:0]  out_tag;
    logic [31:0] stat_imm_count;
    logic [31:0] stat_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    proc_imm_gen_queue #(.p_depth(2), .p_tag_nbits(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_val         (in_val),
        .in_rdy         (in_rdy),
        .in_imm_type    (in_imm_type),
        .in_inst        (in_inst),
        .in_tag         (in_tag),
        .out_val        (out_val),
        .out_rdy        (out_rdy),
        .out_imm        (out_imm),
        .out_err        (out_err),
        .out_tag        (out_tag),
        .stat_imm_count (stat_imm_count),
        .stat_err_count (stat_err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] t, input logic [31:0] inst, input logic [3:0] tag);
        in_val      = 1'b1;
        in_imm_type = t;
        in_inst     = inst;
        in_tag      = tag;
    endtask

    task automatic check_stats(input string name, input int exp_imm, input int exp_err);
`ifdef PROC_IMM_GEN_STATS_EN
        check({name, "_stat_imm"}, stat_imm_count, 32'(exp_imm));
        check({name, "_stat_err"}, stat_err_count, 32'(exp_err));
`else
        check({name, "_stat_imm"}, stat_imm_count, 32'd0);
        check({name, "_stat_err"}, stat_err_count, 32'd0);
        if (exp_imm < 0 || exp_err < 0) n_checks = n_checks + 0;
`endif
    endtask

    initial begin
        reset = 1'b1; in_val = 1'b0; out_rdy = 1'b0;
        in_imm_type = 3'd0; in_inst = 32'd0; in_tag = 4'd0;
        #1;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset / idle
        check("rst_out_val", 32'(out_val), 32'd0);
        check("rst_in_rdy",  32'(in_rdy),  32'd1);
        check("rst_out_imm", out_imm,      32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check_stats("rst", 0, 0);

        // Single-entry encodings with out_rdy=1
        out_rdy = 1'b1;
        drive(3'd0, 32'hFFF00093, 4'd3);
        check("i_in_rdy", 32'(in_rdy), 32'd1);
        check("i_not_yet", 32'(out_val), 32'd0);
        tick(); in_val = 1'b0;
        check("i_out_val", 32'(out_val), 32'd1);
        check("i_imm", out_imm, 32'hFFFFFFFF);
        check("i_err", 32'(out_err), 32'd0);
        check("i_tag", 32'(out_tag), 32'd3);
        tick();
        check("i_drained", 32'(out_val), 32'd0);

        drive(3'd1, 32'hFE112E23, 4'd4);
        tick(); in_val = 1'b0;
        check("s_imm", out_imm, 32'hFFFFFFFC);
        check("s_tag", 32'(out_tag), 32'd4);
        tick();

        drive(3'd4, 32'h001000EF, 4'd5);
        tick(); in_val = 1'b0;
        check("j_imm", out_imm, 32'h00000800);
        tick();

        drive(3'd5, 32'h41F0D093, 4'd6);
        tick(); in_val = 1'b0;
        check("shamt_imm", out_imm, 32'h0000001F);
        tick();

        drive(3'd3, 32'h12345037, 4'd7);
        tick(); in_val = 1'b0;
        check("u_imm", out_imm, 32'h12345000);
        tick();

        drive(3'd2, 32'h00000463, 4'd8);
        tick(); in_val = 1'b0;
        check("b_imm", out_imm, 32'h00000008);
        check("b_err", 32'(out_err), 32'd0);
        tick();
        check_stats("enc", 6, 0);

        // Backpressure: fill depth 2, hold tag 3 off, then simultaneous deq+enq
        out_rdy = 1'b0;
        drive(3'd0, 32'h00100093, 4'd1);
        tick();
        check("bp_rdy_after1", 32'(in_rdy), 32'd1);
        drive(3'd0, 32'h00200093, 4'd2);
        tick();
        drive(3'd0, 32'h00300093, 4'd3);
        check("bp_full_rdy", 32'(in_rdy), 32'd0);
        check("bp_head_tag", 32'(out_tag), 32'd1);
        tick();
        check("bp_held_rdy", 32'(in_rdy), 32'd0);
        check("bp_held_tag", 32'(out_tag), 32'd1);
        check("bp_held_imm", out_imm, 32'd1);
        out_rdy = 1'b1;
        #1;
        check("bp_passthru_rdy", 32'(in_rdy), 32'd1);
        tick(); in_val = 1'b0;
        check("bp_out2_tag", 32'(out_tag), 32'd2);
        check("bp_out2_imm", out_imm, 32'd2);
        tick();
        check("bp_out3_val", 32'(out_val), 32'd1);
        check("bp_out3_tag", 32'(out_tag), 32'd3);
        check("bp_out3_imm", out_imm, 32'd3);
        tick();
        check("bp_empty", 32'(out_val), 32'd0);
        check_stats("bp", 9, 0);

        // Illegal type
        drive(3'd6, 32'hDEADBEEF, 4'd5);
        tick(); in_val = 1'b0;
        check("ill_imm", out_imm, 32'd0);
        check("ill_err", 32'(out_err), 32'd1);
        check("ill_tag", 32'(out_tag), 32'd5);
        tick();
        check_stats("ill", 10, 1);

        // Reset mid-operation discards queued entries
        out_rdy = 1'b0;
        drive(3'd0, 32'h00800093, 4'd8);
        tick();
        drive(3'd0, 32'h00900093, 4'd9);
        tick(); in_val = 1'b0;
        check("mid_full", 32'(in_rdy), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_out_val", 32'(out_val), 32'd0);
        check("mid_in_rdy",  32'(in_rdy),  32'd1);
        check("mid_out_imm", out_imm,      32'd0);
        check("mid_out_tag", 32'(out_tag), 32'd0);
        check_stats("mid", 0, 0);
        out_rdy = 1'b1;
        drive(3'd0, 32'h7FF00093, 4'hA);
        tick(); in_val = 1'b0;
        check("new_tag", 32'(out_tag), 32'hA);
        check("new_imm", out_imm, 32'h000007FF);
        tick();
        check("new_only", 32'(out_val), 32'd0);
        check_stats("new", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
